// File: rtl/pig_pkg.sv
// Constants and face-sequencing helper shared by the Pig game front end and controller.
package pig_pkg;

   localparam int unsigned DICE_W     = 4;
   localparam int unsigned DICE_MIN   = 1;
   localparam int unsigned DICE_MAX   = 6;
   localparam int unsigned ROLL_CNT_W = 8;

   typedef logic [DICE_W-1:0]     dice_t;
   typedef logic [ROLL_CNT_W-1:0] roll_cnt_t;

   function automatic dice_t next_face(input dice_t face);
      return (face == dice_t'(DICE_MAX)) ? dice_t'(DICE_MIN) : face + dice_t'(1);
   endfunction

endpackage

// File: rtl/dice_roller_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer; reusable for any push-button.
module debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic out
);

   localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             out_q;
   logic             out_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   // Any edge where the synchronized level matches the output restarts the count.
   always_comb begin
      cnt_d = '0;
      out_d = out_q;
      if (sync2_q != out_q) begin
         if (cnt_q == CNT_LAST) begin
            out_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign out = out_q;

endmodule

// File: rtl/dice_roller.sv
// Pig game front end: debounced roll button, free-running die face, freeze pulse and roll counter.
module dice_roller
   import pig_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  btn_roll,
   input  logic                  en_roll,
   output logic                  enable,
   output logic [DICE_W-1:0]     dice,
   output logic                  dice_valid,
   output logic [ROLL_CNT_W-1:0] roll_count
);

   dice_t     dice_q;
   dice_t     dice_d;
   logic      en_roll_q;
   logic      dice_valid_q;
   logic      dice_valid_d;
   roll_cnt_t roll_count_q;
   roll_cnt_t roll_count_d;

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock(clock),
      .reset(reset),
      .in   (btn_roll),
      .out  (enable)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dice_q       <= dice_t'(DICE_MIN);
         en_roll_q    <= 1'b0;
         dice_valid_q <= 1'b0;
         roll_count_q <= '0;
      end else begin
         dice_q       <= dice_d;
         en_roll_q    <= en_roll;
         dice_valid_q <= dice_valid_d;
         roll_count_q <= roll_count_d;
      end
   end

   always_comb begin
      dice_d       = dice_q;
      dice_valid_d = en_roll_q & ~en_roll;
      roll_count_d = roll_count_q;
      if (en_roll) begin
         dice_d = next_face(dice_q);
      end
      if (dice_valid_q && (roll_count_q != '1)) begin
         roll_count_d = roll_count_q + roll_cnt_t'(1);
      end
   end

   assign dice       = dice_q;
   assign dice_valid = dice_valid_q;
   assign roll_count = roll_count_q;

endmodule

// File: tb/tb_dice_roller.sv
// Randomized and directed checks of dice_roller against an event-counting reference model.
module tb_dice_roller;
   import pig_pkg::*;

   localparam int unsigned DC = 16;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  btn_roll;
   logic                  en_roll;
   logic                  enable;
   logic [DICE_W-1:0]     dice;
   logic                  dice_valid;
   logic [ROLL_CNT_W-1:0] roll_count;

   int tests = 0;
   int fails = 0;
   bit mon   = 1'b0;

   always #5 clock = ~clock;

   dice_roller #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_roll  (btn_roll),
      .en_roll   (en_roll),
      .enable    (enable),
      .dice      (dice),
      .dice_valid(dice_valid),
      .roll_count(roll_count)
   );

   // Reference model: button samples delayed two edges, enable flips after DC consecutive
   // disagreeing edges, face = 1 + (edges with en_roll high) mod 6, rolls = falling edges seen.
   bit          m_s1, m_s2, m_en, m_prev, m_valid;
   int unsigned m_run, m_adv, m_rolls;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_en = 0; m_prev = 0; m_valid = 0;
         m_run = 0; m_adv = 0; m_rolls = 0;
      end else begin
         if (m_valid && m_rolls < 255) m_rolls++;
         m_valid = m_prev && !en_roll;
         m_prev  = en_roll;
         if (en_roll) m_adv++;
         if (m_s2 != m_en) begin
            m_run++;
            if (m_run == DC) begin
               m_en  = m_s2;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn_roll;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (mon && !reset) begin
         chk("m_enable", 32'(enable), 32'(m_en));
         chk("m_dice", 32'(dice), 32'(1 + (m_adv % 6)));
         chk("m_dice_valid", 32'(dice_valid), 32'(m_valid));
         chk("m_roll_count", 32'(roll_count), m_rolls);
         chk("dice_range", 32'((dice >= 1) && (dice <= 6)), 32'd1);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; btn_roll = 1'b0; en_roll = 1'b0;
      step(3);
      reset = 1'b0;
      mon   = 1'b1;
      for (int i = 0; i < 60; i++) begin
         btn_roll = 1'($urandom);
         en_roll  = 1'($urandom);
         step(1);
      end

      // Asynchronous reset with random inputs, checked before any clock edge
      #2;
      btn_roll = 1'($urandom);
      en_roll  = 1'($urandom);
      reset    = 1'b1;
      #1;
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_dice", 32'(dice), 32'd1);
      chk("rst_valid", 32'(dice_valid), 32'd0);
      chk("rst_count", 32'(roll_count), 32'd0);
      step(2);
      btn_roll = 1'b0; en_roll = 1'b0;
      reset = 1'b0;
      step(3);

      // Clean press: enable rises on edge 18
      btn_roll = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         step(1);
         if (k == 17) chk("press_e17", 32'(enable), 32'd0);
         if (k == 18) chk("press_e18", 32'(enable), 32'd1);
      end
      step(22);
      btn_roll = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         step(1);
         if (k == 17) chk("release_e17", 32'(enable), 32'd1);
         if (k == 18) chk("release_e18", 32'(enable), 32'd0);
      end
      step(5);

      // Bounce: nine toggles every 5 cycles, ending high
      for (int t = 0; t < 9; t++) begin
         btn_roll = ~btn_roll;
         for (int c = 0; c < 5; c++) begin
            step(1);
            if (t < 8) chk("bounce_low", 32'(enable), 32'd0);
         end
      end
      step(8);
      chk("bounce_e13", 32'(enable), 32'd0);
      step(4);
      chk("bounce_e17", 32'(enable), 32'd0);
      step(1);
      chk("bounce_e18", 32'(enable), 32'd1);
      btn_roll = 1'b0;
      step(25);

      // Roll of 8 cycles from face 1
      chk("roll_start", 32'(dice), 32'd1);
      en_roll = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("roll_face", 32'(dice), 32'(((k % 6)) + 1));
      end
      en_roll = 1'b0;
      chk("roll_no_valid", 32'(dice_valid), 32'd0);
      step(1);
      chk("roll_valid", 32'(dice_valid), 32'd1);
      chk("roll_hold", 32'(dice), 32'd3);
      chk("roll_cnt0", 32'(roll_count), 32'd0);
      step(1);
      chk("roll_valid_end", 32'(dice_valid), 32'd0);
      chk("roll_cnt1", 32'(roll_count), 32'd1);
      chk("roll_hold2", 32'(dice), 32'd3);

      // Saturation: 260 one-cycle rolls
      for (int r = 0; r < 260; r++) begin
         en_roll = 1'b1;
         step(1);
         en_roll = 1'b0;
         step(1);
      end
      step(3);
      chk("sat_255", 32'(roll_count), 32'd255);
      en_roll = 1'b1; step(1); en_roll = 1'b0; step(3);
      chk("sat_hold", 32'(roll_count), 32'd255);

      // Reset mid-roll at face 5
      reset = 1'b1; step(1); reset = 1'b0;
      en_roll = 1'b1;
      step(4);
      chk("midroll_face5", 32'(dice), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("midroll_dice", 32'(dice), 32'd1);
      chk("midroll_valid", 32'(dice_valid), 32'd0);
      step(1);
      en_roll = 1'b0;
      reset   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(1);
         chk("post_rst_valid", 32'(dice_valid), 32'd0);
         chk("post_rst_count", 32'(roll_count), 32'd0);
      end

      // Random traffic against the model, with one asynchronous reset mid-way
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) btn_roll = ~btn_roll;
         if ($urandom_range(0, 3) == 0)  en_roll  = ~en_roll;
         if (i == 1500) begin
            #2 reset = 1'b1;
            #2 reset = 1'b0;
         end
         step(1);
      end

      mon = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
